// File: rtl/axi_mem_bridge_if.sv
// AXI-lite channel bundle between the core-side bridge and the memory slave.
// Widths default to 32-bit address/data unless the build defines them.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_WSTRB_WIDTH
`define AXI_WSTRB_WIDTH 4
`endif

interface axi_mem_bridge_if;
    logic                        awvalid;
    logic                        awready;
    logic [`AXI_ADDR_WIDTH-1:0]  awaddr;
    logic [2:0]                  awprot;
    logic                        wvalid;
    logic                        wready;
    logic [`AXI_DATA_WIDTH-1:0]  wdata;
    logic [`AXI_WSTRB_WIDTH-1:0] wstrb;
    logic                        bvalid;
    logic                        bready;
    logic [1:0]                  bresp;
    logic                        arvalid;
    logic                        arready;
    logic [`AXI_ADDR_WIDTH-1:0]  araddr;
    logic [2:0]                  arprot;
    logic                        rvalid;
    logic                        rready;
    logic [`AXI_DATA_WIDTH-1:0]  rdata;
    logic [1:0]                  rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_mem_bridge.sv
// Core native memory request -> single-outstanding AXI-lite read/write bridge.
// Optional hung-slave timeout enabled by defining AXI_MEM_BRIDGE_TIMEOUT_EN.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_WSTRB_WIDTH
`define AXI_WSTRB_WIDTH 4
`endif

module axi_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        mem_valid,
    input  logic                        mem_instr,
    input  logic [`AXI_ADDR_WIDTH-1:0]  mem_addr,
    input  logic [`AXI_DATA_WIDTH-1:0]  mem_wdata,
    input  logic [`AXI_WSTRB_WIDTH-1:0] mem_wstrb,
    output logic                        mem_ready,
    output logic [`AXI_DATA_WIDTH-1:0]  mem_rdata,
    output logic                        mem_err,
    output logic [2:0]                  dbg_state,
    axi_mem_bridge_if.master            m_axi
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WADDR_DATA = 3'd1,
        S_WRESP      = 3'd2,
        S_RADDR      = 3'd3,
        S_RDATA      = 3'd4,
        S_DONE       = 3'd5
    } state_e;

    state_e                        state_q, state_d;
    logic [`AXI_ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [`AXI_DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [`AXI_WSTRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                          instr_q, instr_d;
    logic                          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                          arvalid_q, arvalid_d, rready_q, rready_d;
    logic                          mem_ready_q, mem_ready_d, mem_err_q, mem_err_d;
    logic [`AXI_DATA_WIDTH-1:0]    mem_rdata_q, mem_rdata_d;
    logic                          aw_done, w_done, timeout_hit;

`ifdef AXI_MEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Cleared while idle, so it restarts from zero at every acceptance; saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (state_q != S_DONE && cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_q != S_IDLE) && (state_q != S_DONE) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (res) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // Handshake rule on every channel: a transfer happens on the rising edge where
    // valid and ready are both high; valids come only from flops and stay up until then.
    assign aw_done = !awvalid_q || m_axi.awready;
    assign w_done  = !wvalid_q  || m_axi.wready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        instr_d     = instr_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        mem_ready_d = 1'b0;
        mem_err_d   = 1'b0;
        mem_rdata_d = '0;

        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    if (|mem_wstrb) begin
                        state_d   = S_WADDR_DATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WADDR_DATA: begin
                if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end
            end
            S_WRESP: begin
                if (m_axi.bvalid) begin
                    bready_d    = 1'b0;
                    state_d     = S_DONE;
                    mem_ready_d = 1'b1;
                    mem_err_d   = (m_axi.bresp != 2'b00);
                end
            end
            S_RADDR: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (m_axi.rvalid) begin
                    rready_d    = 1'b0;
                    state_d     = S_DONE;
                    mem_ready_d = 1'b1;
                    mem_err_d   = (m_axi.rresp != 2'b00);
                    mem_rdata_d = m_axi.rdata;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A hung slave: drop every channel and complete toward the core with an error.
        if (timeout_hit) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            state_d     = S_DONE;
            mem_ready_d = 1'b1;
            mem_err_d   = 1'b1;
            mem_rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            instr_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            instr_q     <= instr_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = {instr_q, 2'b00};
    assign m_axi.rready  = rready_q;

    assign mem_ready = mem_ready_q;
    assign mem_err   = mem_err_q;
    assign mem_rdata = mem_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: doc/axi_mem_bridge.md
# axi_mem_bridge

Upstream stage of the AXI-lite `memory` slave: converts the core's native single-outstanding memory request (valid/ready, byte strobes, instruction flag) into AXI-lite write or read transactions on an `if_axi_light` master port and returns read data and completion to the core. One request is in flight at a time. Slave error responses are reported to the core, and an optional timeout guards against a hung slave.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: cycles allowed from request acceptance to B/R handshake; used only with the timeout feature.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `res`  in  1  reset, synchronous, active-high.
- `mem_valid`  in  1  core request valid; held until `mem_ready`.
- `mem_instr`  in  1  request is an instruction fetch.
- `mem_addr`  in  `AXI_ADDR_WIDTH`  byte address, forwarded unmodified.
- `mem_wdata`  in  `AXI_DATA_WIDTH`  write data.
- `mem_wstrb`  in  `AXI_WSTRB_WIDTH`  byte enables; all-zero means read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  `AXI_DATA_WIDTH`  read data, valid while `mem_ready`=1.
- `mem_err`  out  1  pulses with `mem_ready` on SLVERR/DECERR or timeout.
- `m_axi`  if_axi_light.master  AXI-lite channels toward `memory`.

## Operation
- States: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, DONE.
- IDLE: when `mem_valid`=1, latch addr, wdata, wstrb and instr, clear the timeout counter, then branch.
  - Nonzero wstrb: go to WADDR_DATA.
  - Zero wstrb: go to RADDR.
- WADDR_DATA: assert awvalid and wvalid together.
  - Drive awaddr=latched addr, awprot=3'b000, wdata and wstrb from latches.
  - Each valid drops individually after its own handshake (valid and ready high on the same edge).
  - Move to WRESP once both handshakes have completed. They may complete in the same cycle or in either order.
- WRESP: assert bready; on the bvalid handshake capture bresp and go to DONE.
- RADDR: assert arvalid with araddr=latched addr and arprot = {instr,2'b00}. After the handshake go to RDATA.
- RDATA: assert rready; on the rvalid handshake capture rdata and rresp, then go to DONE.
- DONE: for exactly one cycle, pulse `mem_ready`=1 with `mem_rdata` set to the captured data (zero for writes).
  - `mem_err`=1 if resp≠2'b00.
  - Return to IDLE.
  - A new request is not accepted in the DONE cycle.
- Valid signals never depend combinationally on ready. Once asserted, a valid is held until its handshake completes.
- All AXI outputs are driven from registers. Unused channels stay deasserted.
- `mem_valid` dropping mid-transaction is a core protocol error. The bridge ignores it and still completes the transaction.

## Timing
- Reset values (on the edge where `res`=1): state=IDLE; all m_axi valid/ready outputs=0; `mem_ready`=0, `mem_err`=0, `mem_rdata`=0; latches=0.
- Reset mid-transaction: all valids deassert on the next edge and no `mem_ready` is issued. The abandoned transaction's late response is not tracked.
- Cycle 0 is the edge where IDLE samples `mem_valid`. The AXI valid is visible in cycle 1.
- Minimum latency with a zero-wait slave:
  - Write: 4 cycles from acceptance to `mem_ready` (AW/W, B, DONE, plus register stage).
  - Read: 4 cycles.
- Against `memory`, which spends one internal cycle in each of WRITE and READ, expect 5 cycles per access.
- Back-to-back: the next acceptance is possible on the cycle after DONE.

## Configuration
- `AXI_MEM_BRIDGE_TIMEOUT_EN` defined:
  - A counter, width `$clog2(TIMEOUT_CYCLES+1)`, increments in every non-IDLE, non-DONE state.
  - On reaching `TIMEOUT_CYCLES`: deassert all valids/readies, go to DONE, and pulse `mem_ready` with `mem_err`=1 and `mem_rdata`=0.
  - The counter saturates and never wraps.
- Undefined: no counter is instantiated and the bridge waits indefinitely.

## Test plan
- Write: addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF → AW/W handshake, bresp OKAY, single `mem_ready`, `mem_err`=0. A subsequent read of 0x10 returns 0xDEADBEEF.
- Byte write: addr 0x10, wdata 0x000000AA, wstrb 4'b0001 over 0xDEADBEEF → read returns 0xDEADBEAA. awready is delayed 3 cycles after wready, and awvalid must be held throughout.
- Instruction fetch: `mem_instr`=1, addr 0x0 → arprot=3'b100 and `mem_rdata` equals the first `test.hex` word. rvalid stalled 5 cycles → rready held, no early `mem_ready`.
- Out of range: read of addr (`MEM_SIZE`+1)<<2 → slave returns SLVERR, so `mem_ready`=1 and `mem_err`=1.
- Reset during WRESP: assert `res` for 1 cycle → next cycle all valids=0, state IDLE, no `mem_ready`. A following write completes normally.
- With `AXI_MEM_BRIDGE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, arready tied 0 → `mem_ready` and `mem_err` pulse 9–10 cycles after acceptance, and arvalid drops.
